// File: rtl/demux1to8_sipo_pkg.sv
// Shared constants and types for the 1-to-8 demultiplexing deserializer.
// Macro DEMUX_PARITY_EN appends a trailing even-parity slot to every frame.
package demux1to8_sipo_pkg;

   localparam int N = 8;

`ifdef DEMUX_PARITY_EN
   // The parity slot is index N, so the counter needs one extra bit.
   localparam int SEL_W     = $clog2(N + 1);
   localparam int LAST_SLOT = N;
`else
   localparam int SEL_W     = $clog2(N);
   localparam int LAST_SLOT = N - 1;
`endif

   typedef logic [N-1:0]     frame_t;
   typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/demux1to8_sipo_if.sv
// Serial-in / byte-out handshake bundle for demux1to8_sipo.
// The master drives the serial side and consumes frames; the slave is the deserializer.
interface demux1to8_sipo_if;
   import demux1to8_sipo_pkg::*;

   logic   din;
   logic   din_valid;
   logic   din_ready;
   frame_t q;
   logic   q_valid;
   logic   q_ready;
   sel_t   sel;
   logic   parity_err;

   modport master (
      output din, din_valid, q_ready,
      input  din_ready, q, q_valid, sel, parity_err
   );

   modport slave (
      input  din, din_valid, q_ready,
      output din_ready, q, q_valid, sel, parity_err
   );

endinterface

// File: rtl/demux1to8_sipo_lane_wr.sv
// Combinational 1-to-N demux producing per-lane write enables from sel and the
// transfer strobe; a sel outside 0..N-1 (the parity slot) enables no lane.
module demux_lane_wr
   import demux1to8_sipo_pkg::*;
(
   input  sel_t   sel,
   input  logic   wr,
   output frame_t we
);

   always_comb begin
      we = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (wr && (sel == sel_t'(i))) we[i] = 1'b1;
      end
   end

endmodule

// File: rtl/demux1to8_sipo.sv
// 1-to-8 demultiplexing deserializer: LSB-first serial bits into a 1-entry frame buffer.
// Macro DEMUX_PARITY_EN adds a trailing even-parity bit checked into parity_err.
module demux1to8_sipo
   import demux1to8_sipo_pkg::*;
(
   input logic             clk,
   input logic             rst,
   demux1to8_sipo_if.slave bus
);

   sel_t   sel_r;
   frame_t acc_r;
   frame_t acc_nxt;
   frame_t q_r;
   frame_t we;
   logic   q_valid_r;
   logic   last_slot;
   logic   din_ready;
   logic   xfer;
   logic   load;

   assign last_slot = (sel_r == sel_t'(LAST_SLOT));
   // The last bit stalls only while an unconsumed frame blocks the buffer.
   assign din_ready = !(last_slot && q_valid_r && !bus.q_ready);
   assign xfer      = bus.din_valid && din_ready;
   assign load      = xfer && last_slot;

   demux_lane_wr u_lane_wr (
      .sel (sel_r),
      .wr  (xfer),
      .we  (we)
   );

   // The frame loaded into q is the accumulator with this cycle's bit already merged.
   always_comb begin
      acc_nxt = acc_r;
      for (int unsigned i = 0; i < N; i++) begin
         if (we[i]) acc_nxt[i] = bus.din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_r     <= '0;
         acc_r     <= '0;
         q_r       <= '0;
         q_valid_r <= 1'b0;
      end else begin
         if (xfer) begin
            if (load) begin
               sel_r <= '0;
               acc_r <= '0;
            end else begin
               sel_r <= sel_r + sel_t'(1);
               acc_r <= acc_nxt;
            end
         end
         if (load) begin
            q_r       <= acc_nxt;
            q_valid_r <= 1'b1;
         end else if (q_valid_r && bus.q_ready) begin
            q_valid_r <= 1'b0;
         end
      end
   end

`ifdef DEMUX_PARITY_EN
   logic parity_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         parity_r <= 1'b0;
      end else if (load) begin
         parity_r <= (^acc_nxt) ^ bus.din;
      end
   end

   assign bus.parity_err = parity_r;
`else
   assign bus.parity_err = 1'b0;
`endif

   assign bus.din_ready = din_ready;
   assign bus.q         = q_r;
   assign bus.q_valid   = q_valid_r;
   assign bus.sel       = sel_r;

endmodule

// File: tb/tb_demux1to8_sipo.sv
// Directed self-checking bench for demux1to8_sipo; frames carry a trailing
// even-parity bit when DEMUX_PARITY_EN is defined.
module tb_demux1to8_sipo;
   import demux1to8_sipo_pkg::*;

   localparam int FL = LAST_SLOT + 1;

   logic clk = 1'b0;
   logic rst;
   int   compared   = 0;
   int   mismatched = 0;

   demux1to8_sipo_if bus_if ();

   demux1to8_sipo dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   // Frame bits in transmit order: data LSB first, then the parity bit if enabled.
   function automatic logic [8:0] frame_bits(input logic [7:0] data, input logic pbit);
      return {pbit, data};
   endfunction

   // Inputs change and outputs are sampled on the falling edge.
   task automatic send_bit(input logic b);
      int unsigned waited = 0;
      bus_if.din       = b;
      bus_if.din_valid = 1'b1;
      while (bus_if.din_ready !== 1'b1 && waited < 64) begin
         @(negedge clk);
         waited++;
      end
      compared++;
      if (bus_if.din_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL send_bit_timeout: din_ready=%b required 1", bus_if.din_ready);
      end
      @(negedge clk);
      bus_if.din_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] data, input logic pbit);
      logic [8:0] bits;
      bits = frame_bits(data, pbit);
      for (int i = 0; i < FL; i++) send_bit(bits[i]);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      compared += 5;
      if (bus_if.sel !== sel_t'(0)) begin mismatched++; $display("FAIL reset_sel: got %0d want 0", bus_if.sel); end
      if (bus_if.q_valid !== 1'b0) begin mismatched++; $display("FAIL reset_q_valid: got %b want 0", bus_if.q_valid); end
      if (bus_if.q !== 8'h00) begin mismatched++; $display("FAIL reset_q: got %h want 00", bus_if.q); end
      if (bus_if.parity_err !== 1'b0) begin mismatched++; $display("FAIL reset_parity_err: got %b want 0", bus_if.parity_err); end
      if (bus_if.din_ready !== 1'b1) begin mismatched++; $display("FAIL reset_din_ready: got %b want 1", bus_if.din_ready); end
   endtask

   task automatic test_reset_mid_frame();
      bus_if.q_ready = 1'b1;
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      compared++;
      if (bus_if.sel !== sel_t'(5)) begin mismatched++; $display("FAIL midframe_sel: got %0d want 5", bus_if.sel); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      compared += 3;
      if (bus_if.sel !== sel_t'(0)) begin mismatched++; $display("FAIL midframe_rst_sel: got %0d want 0", bus_if.sel); end
      if (bus_if.q_valid !== 1'b0) begin mismatched++; $display("FAIL midframe_rst_q_valid: got %b want 0", bus_if.q_valid); end
      if (bus_if.q !== 8'h00) begin mismatched++; $display("FAIL midframe_rst_q: got %h want 00", bus_if.q); end
      // bits 1,0,1,1,0,0,1,0 LSB first -> 8'h4D (four ones, even parity 0)
      send_frame(8'h4D, 1'b0);
      compared += 2;
      if (bus_if.q_valid !== 1'b1) begin mismatched++; $display("FAIL midframe_q_valid: got %b want 1", bus_if.q_valid); end
      if (bus_if.q !== 8'h4D) begin mismatched++; $display("FAIL midframe_q: got %h want 4d", bus_if.q); end
      @(negedge clk);
      compared++;
      if (bus_if.q_valid !== 1'b0) begin mismatched++; $display("FAIL midframe_consume: q_valid=%b want 0", bus_if.q_valid); end
   endtask

   task automatic test_stream();
      logic [17:0] stream;
      bus_if.q_ready = 1'b1;
      stream = 18'h0;
      stream[FL-1:0]      = FL'(frame_bits(8'hA5, 1'b0));
      stream[2*FL-1 -: FL] = FL'(frame_bits(8'h3C, 1'b0));
      for (int e = 0; e < 2 * FL; e++) begin
         compared += 2;
         if (bus_if.din_ready !== 1'b1) begin mismatched++; $display("FAIL stream_din_ready[%0d]: got %b want 1", e, bus_if.din_ready); end
         if (bus_if.q_valid !== (e == FL)) begin mismatched++; $display("FAIL stream_q_valid[%0d]: got %b want %b", e, bus_if.q_valid, (e == FL)); end
         if (e == FL) begin
            compared++;
            if (bus_if.q !== 8'hA5) begin mismatched++; $display("FAIL stream_q0: got %h want a5", bus_if.q); end
         end
         bus_if.din       = stream[e];
         bus_if.din_valid = 1'b1;
         @(negedge clk);
      end
      bus_if.din_valid = 1'b0;
      compared += 2;
      if (bus_if.q_valid !== 1'b1) begin mismatched++; $display("FAIL stream_q_valid_end: got %b want 1", bus_if.q_valid); end
      if (bus_if.q !== 8'h3C) begin mismatched++; $display("FAIL stream_q1: got %h want 3c", bus_if.q); end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      logic [8:0] bits;
      bus_if.q_ready = 1'b0;
      send_frame(8'hFF, 1'b0);
      bits = frame_bits(8'h5A, 1'b0);
      for (int i = 0; i < FL - 1; i++) send_bit(bits[i]);
      bus_if.din       = bits[FL-1];
      bus_if.din_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         compared += 4;
         if (bus_if.din_ready !== 1'b0) begin mismatched++; $display("FAIL bp_din_ready[%0d]: got %b want 0", c, bus_if.din_ready); end
         if (bus_if.sel !== sel_t'(LAST_SLOT)) begin mismatched++; $display("FAIL bp_sel[%0d]: got %0d want %0d", c, bus_if.sel, LAST_SLOT); end
         if (bus_if.q !== 8'hFF) begin mismatched++; $display("FAIL bp_q_hold[%0d]: got %h want ff", c, bus_if.q); end
         if (bus_if.q_valid !== 1'b1) begin mismatched++; $display("FAIL bp_q_valid[%0d]: got %b want 1", c, bus_if.q_valid); end
         @(negedge clk);
      end
      bus_if.q_ready = 1'b1;
      #1;
      compared++;
      if (bus_if.din_ready !== 1'b1) begin mismatched++; $display("FAIL bp_release_ready: got %b want 1", bus_if.din_ready); end
      @(negedge clk);
      bus_if.din_valid = 1'b0;
      compared += 3;
      if (bus_if.q_valid !== 1'b1) begin mismatched++; $display("FAIL bp_swap_q_valid: got %b want 1", bus_if.q_valid); end
      if (bus_if.q !== 8'h5A) begin mismatched++; $display("FAIL bp_swap_q: got %h want 5a", bus_if.q); end
      if (bus_if.sel !== sel_t'(0)) begin mismatched++; $display("FAIL bp_swap_sel: got %0d want 0", bus_if.sel); end
      @(negedge clk);
      compared++;
      if (bus_if.q_valid !== 1'b0) begin mismatched++; $display("FAIL bp_drain: q_valid=%b want 0", bus_if.q_valid); end
   endtask

   task automatic test_sparse();
      logic [8:0] bits;
      logic [3:0] pattern;
      int         accepted;
      int         cyc;
      bits     = frame_bits(8'h81, 1'b0);
      pattern  = 4'b1001;
      accepted = 0;
      cyc      = 0;
      bus_if.q_ready = 1'b1;
      while (accepted < FL && cyc < 100) begin
         compared++;
         if (bus_if.sel !== sel_t'(accepted)) begin mismatched++; $display("FAIL sparse_sel[%0d]: got %0d want %0d", cyc, bus_if.sel, accepted); end
         bus_if.din_valid = pattern[cyc % 4];
         bus_if.din       = pattern[cyc % 4] ? bits[accepted] : ~bits[accepted];
         @(negedge clk);
         if (pattern[cyc % 4]) accepted++;
         cyc++;
      end
      bus_if.din_valid = 1'b0;
      compared += 4;
      if (accepted != FL) begin mismatched++; $display("FAIL sparse_timeout: accepted %0d want %0d", accepted, FL); end
      if (bus_if.q_valid !== 1'b1) begin mismatched++; $display("FAIL sparse_q_valid: got %b want 1", bus_if.q_valid); end
      if (bus_if.q !== 8'h81) begin mismatched++; $display("FAIL sparse_q: got %h want 81", bus_if.q); end
      if (bus_if.parity_err !== 1'b0) begin mismatched++; $display("FAIL sparse_parity_err: got %b want 0", bus_if.parity_err); end
      @(negedge clk);
   endtask

`ifdef DEMUX_PARITY_EN
   task automatic test_parity();
      bus_if.q_ready = 1'b1;
      for (int i = 0; i < N; i++) send_bit(i < 3);
      compared++;
      if (bus_if.sel !== sel_t'(N)) begin mismatched++; $display("FAIL parity_slot_sel: got %0d want %0d", bus_if.sel, N); end
      send_bit(1'b1);
      compared += 3;
      if (bus_if.q !== 8'h07) begin mismatched++; $display("FAIL parity_good_q: got %h want 07", bus_if.q); end
      if (bus_if.q_valid !== 1'b1) begin mismatched++; $display("FAIL parity_good_q_valid: got %b want 1", bus_if.q_valid); end
      if (bus_if.parity_err !== 1'b0) begin mismatched++; $display("FAIL parity_good_err: got %b want 0", bus_if.parity_err); end
      send_frame(8'h07, 1'b0);
      compared += 3;
      if (bus_if.q !== 8'h07) begin mismatched++; $display("FAIL parity_bad_q: got %h want 07", bus_if.q); end
      if (bus_if.q_valid !== 1'b1) begin mismatched++; $display("FAIL parity_bad_q_valid: got %b want 1", bus_if.q_valid); end
      if (bus_if.parity_err !== 1'b1) begin mismatched++; $display("FAIL parity_bad_err: got %b want 1", bus_if.parity_err); end
      @(negedge clk);
   endtask
`endif

   task automatic test_consume_reset();
      bus_if.q_ready = 1'b1;
      send_frame(8'hC3, 1'b0);
      compared++;
      if (bus_if.q_valid !== 1'b1) begin mismatched++; $display("FAIL crst_pre_q_valid: got %b want 1", bus_if.q_valid); end
      bus_if.din       = 1'b1;
      bus_if.din_valid = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus_if.din_valid = 1'b0;
      compared += 3;
      if (bus_if.q_valid !== 1'b0) begin mismatched++; $display("FAIL crst_q_valid: got %b want 0", bus_if.q_valid); end
      if (bus_if.q !== 8'h00) begin mismatched++; $display("FAIL crst_q: got %h want 00", bus_if.q); end
      if (bus_if.sel !== sel_t'(0)) begin mismatched++; $display("FAIL crst_sel: got %0d want 0", bus_if.sel); end
   endtask

   initial begin
      rst              = 1'b1;
      bus_if.din       = 1'b0;
      bus_if.din_valid = 1'b0;
      bus_if.q_ready   = 1'b0;
      @(negedge clk);
      test_reset();
      test_reset_mid_frame();
      test_stream();
      test_backpressure();
      test_sparse();
`ifdef DEMUX_PARITY_EN
      test_parity();
`endif
      test_consume_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/demux1to8_sipo.md
Name: demux1to8_sipo

Overview:
- Inverse of the 8-to-1 selector path: a 1-to-8 demultiplexing deserializer.
- Accepts a serial bit stream under a valid/ready handshake and steers each bit into output lane d[sel]; a 3-bit counter drives sel.
- After 8 bits it presents the assembled byte on a registered parallel output with its own valid/ready handshake.
- Sits between a serial link front-end and byte-wide consumer logic.

Parameters:
- N, 8, number of demux lanes (bits per frame); design is verified at 8 only.
- SEL_W, 3, select/counter width, equal to clog2(N).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
- din  input  1  serial data bit.
- din_valid  input  1  din carries a bit this cycle.
- din_ready  output  1  block accepts din this cycle.
- q  output  N  assembled frame, registered; bit i = i-th accepted bit of the frame.
- q_valid  output  1  q holds an unconsumed frame.
- q_ready  input  1  consumer takes q this cycle.
- sel  output  SEL_W  current demux lane (index of the next bit to be written).
- parity_err  output  1  parity flag for the frame in q (see Optional Feature).

Behaviour:
- Reset (rst=1 at a clock edge): sel=0, accumulator=0, q=0, q_valid=0, parity_err=0. Reset overrides every other event in the same cycle; a partial frame is discarded.
- Bit transfer occurs on an edge where din_valid && din_ready; write din into acc[sel] and increment sel.
- LSB first: the bit accepted with sel=k lands in q[k], matching the forward selector mapping s=k -> d[k].
- No transfer: sel and acc hold.
- Last bit (sel==N-1, or the parity slot when the optional feature is compiled in):
  - If !q_valid || q_ready: q <= {din, acc[N-2:0]}, q_valid=1, sel wraps to 0, acc cleared.
  - Else din_ready=0 and the last bit is stalled, not dropped. No overflow condition exists.
- din_ready = !(last_slot && q_valid && !q_ready). It is combinational from q_valid, q_ready and sel only, never from din_valid.
- Output side: q_valid clears on q_valid && q_ready unless a new frame loads in the same cycle, in which case q_valid stays 1 and q takes the new frame.
- q is stable while q_valid && !q_ready.
- Latency: q_valid rises the edge after the final bit is accepted. Throughput is one bit per clock, with back-to-back frames needing no bubble when q_ready=1.
- Gaps in din_valid are legal at any position; sel simply holds.
- State: no explicit FSM beyond sel, which acts as a COLLECT counter with wrap. The output buffer is a 1-entry holding register.

Optional Feature:
- Macro DEMUX_PARITY_EN.
- Defined:
  - Frame is N data bits plus one trailing even-parity bit; sel counts 0..N, with slot N as the last slot.
  - The parity bit is not stored in q.
  - parity_err loads with the frame: 1 if XOR(data bits, parity bit)=1, else 0.
  - The frame is delivered even when parity_err=1.
- Not defined: frame is N bits, sel counts 0..N-1, and parity_err is tied 0.

Decomposition:
- Shared package holds:
  - constants N=8 and SEL_W=3;
  - LAST_SLOT, equal to N-1, or N with DEMUX_PARITY_EN;
  - the frame-word typedef.
- One sub-module is natural: demux_lane_wr, a combinational 1-to-N demux that produces the per-lane write enables from sel and the transfer strobe. It is the structural mirror of the forward selector.
- The counter and holding register stay in the top.

Test Plan:
- Reset mid-frame: send 5 bits, assert rst for 1 cycle -> sel=0, q_valid=0, q=0; next 8 bits 1,0,1,1,0,0,1,0 give q=8'h4D.
- Continuous stream, q_ready=1: frames 8'hA5 then 8'h3C back-to-back -> q_valid high on cycles 9 and 17, q=A5 then 3C, din_ready never drops.
- Backpressure: q_ready=0 with frame 8'hFF held and a second frame reaching sel=7 -> din_ready=0 and sel holds at 7. Raising q_ready -> 8'hFF consumed and the new frame loaded on the same edge, q_valid stays 1.
- Sparse input: din_valid toggled 1,0,0,1 across the frame for 8'h81 -> q=8'h81, with sel advancing only on accepted bits.
- With DEMUX_PARITY_EN: data 8'h07 plus parity 1 -> parity_err=0. Data 8'h07 plus parity 0 -> parity_err=1, q=8'h07, frame length 9 bits.
- Simultaneous consume and reset: q_valid=1, q_ready=1, rst=1 -> q_valid=0 and q=0 next cycle.
